// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite SRAM responder: response codes and
// the 3-bit state encoding used by the controller FSM.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

endpackage

// File: rtl/axil_sram_slave_if.sv
// AXI4-Lite bus between the arbiter memory port (master) and the SRAM
// responder (slave).
//
// Handshake rule for every channel: a transfer happens on the rising clk
// edge where both valid and ready are high. A source holds its valid and
// payload stable until that edge; the responder's payload (rdata/rresp,
// bresp) stays stable while its valid is high and ready is low.
interface axil_sram_slave_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded 8'hA5 on reset.
// Advances every cycle; used as a per-transaction latency source.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  // Shift left, feeding back the taps of the polynomial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 8'hA5;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM responder: one read or write outstanding at a time, word
// array behind a base address, response after a fixed wait.
// Optional build macro SRAM_RAND_LAT_EN: per-transaction latency comes from
// lfsr8 (0..15) instead of LATENCY.
module axil_sram_slave
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1
) (
  input  logic                clk,
  input  logic                rst,
  axil_sram_slave_if.slave    bus,
  output logic [2:0]          state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SRAM_RAND_LAT_EN
  localparam int MAX_LAT = 15;
`else
  localparam int MAX_LAT = LATENCY;
`endif
  localparam int CNT_W = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  logic [31:0]      mem [DEPTH];
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_val;
  logic [AW-1:0]    rd_idx;
  logic             rd_ok;
  logic             wr_ok;
  logic [31:0]      ar_off;
  logic [31:0]      aw_off;
  logic             ar_in;
  logic             aw_in;
  logic             ar_hs;
  logic             wr_hs;
  logic [AW-1:0]    rd_src_idx;
  logic             rd_src_ok;

  // Address decode: word index relative to BASE_ADDR, low byte bits ignored.
  assign ar_off = bus.araddr - BASE_ADDR;
  assign aw_off = bus.awaddr - BASE_ADDR;
  assign ar_in  = ({2'b00, ar_off[31:2]} < 32'(DEPTH));
  assign aw_in  = ({2'b00, aw_off[31:2]} < 32'(DEPTH));

  // Readies are a pure function of state (and arvalid for the write side),
  // so they are up before the master raises valid. Reads have priority.
  assign bus.arready = !rst && (state == ST_IDLE);
  assign bus.awready = !rst && (state == ST_IDLE) && !bus.arvalid;
  assign bus.wready  = bus.awready;
  assign ar_hs       = bus.arready && bus.arvalid;
  assign wr_hs       = bus.awready && bus.awvalid && bus.wready && bus.wvalid;

  assign bus.rvalid  = (state == ST_RD_RESP);
  assign bus.bvalid  = (state == ST_WR_RESP);
  assign state_dbg   = state;

`ifdef SRAM_RAND_LAT_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;
  lfsr8 u_lfsr (.clk(clk), .rst(rst), .q(lfsr_q));
  assign lat_val     = lfsr_q[3:0];
  assign unused_lfsr = ^lfsr_q[7:4];
`else
  assign lat_val = CNT_W'(LATENCY);
`endif

  // Read data source: the live address on a zero-wait handshake, otherwise
  // the index latched at the handshake.
  assign rd_src_idx = (state == ST_IDLE) ? ar_off[AW+1:2] : rd_idx;
  assign rd_src_ok  = (state == ST_IDLE) ? ar_in : rd_ok;

  logic unused_bits;
  assign unused_bits = ^{bus.wstrb[7:4], ar_off[1:0], aw_off[1:0]};

  // Controller FSM: handshake, wait countdown, response hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rd_idx    <= '0;
      rd_ok     <= 1'b0;
      wr_ok     <= 1'b0;
      bus.rdata <= 32'h0;
      bus.rresp <= RESP_OKAY;
      bus.bresp <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            rd_idx <= ar_off[AW+1:2];
            rd_ok  <= ar_in;
            if (lat_val != '0) begin
              state <= ST_RD_WAIT;
              cnt   <= lat_val - CNT_W'(1);
            end else begin
              state     <= ST_RD_RESP;
              bus.rdata <= rd_src_ok ? mem[rd_src_idx] : 32'h0;
              bus.rresp <= rd_src_ok ? RESP_OKAY : RESP_DECERR;
            end
          end else if (wr_hs) begin
            wr_ok <= aw_in;
            if (lat_val != '0) begin
              state <= ST_WR_WAIT;
              cnt   <= lat_val - CNT_W'(1);
            end else begin
              state     <= ST_WR_RESP;
              bus.bresp <= aw_in ? RESP_OKAY : RESP_DECERR;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_RD_RESP;
            bus.rdata <= rd_src_ok ? mem[rd_src_idx] : 32'h0;
            bus.rresp <= rd_src_ok ? RESP_OKAY : RESP_DECERR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RD_RESP: if (bus.rready) state <= ST_IDLE;
        ST_WR_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_WR_RESP;
            bus.bresp <= wr_ok ? RESP_OKAY : RESP_DECERR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WR_RESP: if (bus.bready) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Byte-masked array write on the write handshake edge; out-of-range drops.
  always_ff @(posedge clk) begin
    if (wr_hs && aw_in) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[aw_off[AW+1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave (default build, LATENCY = 2).
module tb_axil_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam int          TMO   = 64;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  axil_sram_slave_if bus();

  axil_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];

  function automatic bit model_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) < 32'(DEPTH);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!model_in_range(a)) return 32'h0;
    if (!ref_mem.exists(model_idx(a))) return 32'hxxxx_xxxx;
    return ref_mem[model_idx(a)];
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return model_in_range(a) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    logic [31:0] w;
    if (!model_in_range(a)) return;
    w = ref_mem.exists(model_idx(a)) ? ref_mem[model_idx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[model_idx(a)] = w;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    n = 0;
    while (bus.awready !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) begin checks++; errors++; $display("FAIL aw_timeout: awready got %b required 1", bus.awready); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = 0; resp = 2'bxx;
    while (lat < TMO) begin @(negedge clk); lat++; if (bus.bvalid === 1'b1) break; end
    if (bus.bvalid !== 1'b1) begin
      checks++; errors++; $display("FAIL b_timeout: bvalid got %b required 1", bus.bvalid);
    end else begin
      resp = bus.bresp;
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (bus.arready !== 1'b1 && n < TMO) begin @(negedge clk); #1; n++; end
    if (n >= TMO) begin checks++; errors++; $display("FAIL ar_timeout: arready got %b required 1", bus.arready); end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 0; data = 32'hx; resp = 2'bxx;
    while (lat < TMO) begin @(negedge clk); lat++; if (bus.rvalid === 1'b1) break; end
    if (bus.rvalid !== 1'b1) begin
      checks++; errors++; $display("FAIL r_timeout: rvalid got %b required 1", bus.rvalid);
    end else begin
      data = bus.rdata; resp = bus.rresp;
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b required 0", bus.rvalid); end
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b required 0", bus.bvalid); end
    checks++; if (bus.rresp !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b required 00", bus.rresp); end
    checks++; if (bus.bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b required 00", bus.bresp); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", bus.rdata); end
    checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b required 0", bus.arready); end
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b required 0", bus.awready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL post_rst_arready: got %b required 1", bus.arready); end
    checks++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      errors++; $display("FAIL post_rst_awready: got %b/%b required 1/1", bus.awready, bus.wready);
    end
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(BASE + 32'h10, 32'hDEADBEEF, 8'h0F, resp, lat);
    model_write(BASE + 32'h10, 32'hDEADBEEF, 8'h0F);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b required 00", resp); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL wr_latency: got %0d required %0d", lat, LAT + 1); end
    axi_read(BASE + 32'h10, d, resp, lat);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h required deadbeef", d); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp: got %b required 00", resp); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL rd_latency: got %0d required %0d", lat, LAT + 1); end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(BASE + 32'h10, 32'h11223344, 8'h05, resp, lat);
    model_write(BASE + 32'h10, 32'h11223344, 8'h05);
    axi_read(BASE + 32'h10, d, resp, lat);
    checks++; if (d !== 32'hDE22BE44) begin errors++; $display("FAIL strobe_05: got %h required de22be44", d); end
    // Upper strobe bits carry no meaning: an F0 strobe writes nothing.
    axi_write(BASE + 32'h10, 32'hAABBCCDD, 8'hF0, resp, lat);
    model_write(BASE + 32'h10, 32'hAABBCCDD, 8'hF0);
    axi_read(BASE + 32'h10, d, resp, lat);
    checks++; if (d !== model_read(BASE + 32'h10)) begin
      errors++; $display("FAIL strobe_f0: got %h required %h", d, model_read(BASE + 32'h10));
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; int lat;
    axi_write(BASE, 32'h0BADF00D, 8'h0F, resp, lat);
    model_write(BASE, 32'h0BADF00D, 8'h0F);
    axi_read(BASE + 32'h4000, d, resp, lat);
    checks++; if (resp !== 2'b11) begin errors++; $display("FAIL oor_rresp: got %b required 11", resp); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h required 0", d); end
    axi_write(BASE + 32'h4000, 32'hFFFFFFFF, 8'hFF, resp, lat);
    checks++; if (resp !== 2'b11) begin errors++; $display("FAIL oor_bresp: got %b required 11", resp); end
    axi_read(BASE, d, resp, lat);
    checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL oor_no_alias: got %h required 0badf00d", d); end
    axi_read(BASE - 32'h4, d, resp, lat);
    checks++; if (resp !== 2'b11) begin errors++; $display("FAIL below_base_rresp: got %b required 11", resp); end
    // Last word of the array is still in range.
    axi_write(BASE + 32'h3FFC, 32'h5A5A1234, 8'h0F, resp, lat);
    model_write(BASE + 32'h3FFC, 32'h5A5A1234, 8'h0F);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL last_word_bresp: got %b required 00", resp); end
    axi_read(BASE + 32'h3FFC, d, resp, lat);
    checks++; if (d !== 32'h5A5A1234) begin errors++; $display("FAIL last_word_rdata: got %h required 5a5a1234", d); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] exp;
    exp = model_read(BASE + 32'h10);
    @(negedge clk);
    bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (n < TMO) begin @(negedge clk); n++; if (bus.rvalid === 1'b1) break; end
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL bp_rvalid_rise: got %b required 1", bus.rvalid); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp || bus.arready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: rvalid %b rdata %h arready %b required 1 %h 0", i, bus.rvalid, bus.rdata, bus.arready, exp);
      end
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    @(negedge clk);
    checks++; if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
      errors++; $display("FAIL bp_release: arready %b rvalid %b required 1 0", bus.arready, bus.rvalid);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] resp; logic [31:0] d; int lat; int n;
    axi_write(BASE + 32'h20, 32'h12345678, 8'h0F, resp, lat);
    model_write(BASE + 32'h20, 32'h12345678, 8'h0F);
    @(negedge clk);
    bus.araddr = BASE + 32'h20; bus.arvalid = 1'b1;
    bus.awaddr = BASE + 32'h20; bus.wdata = 32'hCAFEF00D; bus.wstrb = 8'h0F;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    checks++; if (bus.arready !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
      errors++; $display("FAIL sim_ready: ar %b aw %b w %b required 1 0 0", bus.arready, bus.awready, bus.wready);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (n < TMO) begin @(negedge clk); n++; if (bus.rvalid === 1'b1) break; end
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h12345678) begin
      errors++; $display("FAIL sim_read_first: rvalid %b rdata %h required 1 12345678", bus.rvalid, bus.rdata);
    end
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL sim_aw_blocked: got %b required 0", bus.awready); end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    @(negedge clk);
    checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL sim_aw_accept: got %b required 1", bus.awready); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    model_write(BASE + 32'h20, 32'hCAFEF00D, 8'h0F);
    n = 0;
    while (n < TMO) begin @(negedge clk); n++; if (bus.bvalid === 1'b1) break; end
    checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || n != LAT + 1) begin
      errors++; $display("FAIL sim_write_resp: bvalid %b bresp %b cycles %0d required 1 00 %0d", bus.bvalid, bus.bresp, n, LAT + 1);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    axi_read(BASE + 32'h20, d, resp, lat);
    checks++; if (d !== model_read(BASE + 32'h20)) begin
      errors++; $display("FAIL sim_readback: got %h required %h", d, model_read(BASE + 32'h20));
    end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] resp; logic [31:0] d; int lat;
    bit saw_rvalid;
    saw_rvalid = 1'b0;
    @(negedge clk);
    bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    if (bus.rvalid === 1'b1) saw_rvalid = 1'b1;
    rst = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.rvalid !== 1'b0) saw_rvalid = 1'b1; end
    rst = 1'b0;
    #1;
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL rst_mid_arready: got %b required 1", bus.arready); end
    repeat (LAT + 4) begin @(negedge clk); if (bus.rvalid !== 1'b0) saw_rvalid = 1'b1; end
    checks++; if (saw_rvalid) begin errors++; $display("FAIL rst_mid_rvalid: got 1 required 0"); end
    axi_read(BASE + 32'h10, d, resp, lat);
    checks++; if (d !== model_read(BASE + 32'h10) || resp !== 2'b00) begin
      errors++; $display("FAIL rst_mid_keep: got %h/%b required %h/00", d, resp, model_read(BASE + 32'h10));
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] a; logic [31:0] d; logic [31:0] exp; logic [7:0] s; int lat;
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      axi_write(BASE + 32'(4 * k), d, 8'h0F, resp, lat);
      model_write(BASE + 32'(4 * k), d, 8'h0F);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0)
        a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 255));
      else
        a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        exp_q.push_back(model_read(a));
        axi_read(a, d, resp, lat);
        exp = exp_q.pop_front();
        checks++; if (d !== exp || resp !== model_resp(a) || lat != LAT + 1) begin
          errors++; $display("FAIL rand_read_%0d @%h: got %h/%b/%0d required %h/%b/%0d", i, a, d, resp, lat, exp, model_resp(a), LAT + 1);
        end
      end else begin
        d = $urandom;
        s = 8'($urandom_range(0, 255));
        axi_write(a, d, s, resp, lat);
        model_write(a, d, s);
        checks++; if (resp !== model_resp(a) || lat != LAT + 1) begin
          errors++; $display("FAIL rand_write_%0d @%h: got %b/%0d required %b/%0d", i, a, resp, lat, model_resp(a), LAT + 1);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
